// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 block sequencer.
// The state encoding is fixed at 3 bits so it can be observed on a debug bus.
package sha256_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FETCH = 3'd2,
    ROUND = 3'd3,
    ADD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;
  localparam int RIDX_W    = 6;

  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);
  localparam logic [RIDX_W-1:0] LAST_FETCH = RIDX_W'(MSG_WORDS - 1);

endpackage

// File: rtl/sha256_round_cnt.sv
// Round counter for the compression loop: cleared before each block,
// advanced once per round, and held at the final round instead of wrapping.
module sha256_round_cnt
  import sha256_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [RIDX_W-1:0] count,
  output logic              last
);

  assign last = (count == LAST_ROUND);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Top-level sequencer for the SHA-256 compression datapath: hash init,
// per-block variable load, 64 rounds with aligned message fetch, hash update.
module sha256_block_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int BLK_W  = 8,
  parameter int ADDR_W = BLK_W + 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BLK_W-1:0]  num_blocks,
  output logic              busy,
  output logic              init_hash,
  output logic              load_vars,
  output logic              msg_rd_en,
  output logic [ADDR_W-1:0] msg_addr,
  output logic              round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              w_sel,
  output logic              update_hash,
  output logic              done
);

  localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);

  state_t            state;
  state_t            state_next;
  logic [BLK_W-1:0]  block_cnt;
  logic [BLK_W-1:0]  num_lat;
  logic              last_block;
  logic [RIDX_W-1:0] round_cnt;
  logic              round_last;
  logic              accept;
  logic [3:0]        word_idx;

  assign accept     = (state == IDLE) && start && (num_blocks != '0);
  assign last_block = (block_cnt == (num_lat - BLK_ONE));

  sha256_round_cnt u_round_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == FETCH),
    .enable (state == ROUND),
    .count  (round_cnt),
    .last   (round_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_blocks == '0) ? DONE : INIT;
        end
      end
      INIT:    state_next = FETCH;
      FETCH:   state_next = ROUND;
      ROUND:   state_next = round_last ? ADD : ROUND;
      ADD:     state_next = last_block ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Block count is only advanced between blocks, so it stops at num_lat-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_cnt <= '0;
      num_lat   <= '0;
    end else if (accept) begin
      block_cnt <= '0;
      num_lat   <= num_blocks;
    end else if ((state == ADD) && !last_block) begin
      block_cnt <= block_cnt + BLK_ONE;
    end
  end

  // Memory has one cycle of read latency, so round r fetches word r+1.
  assign word_idx = round_cnt[3:0] + 4'd1;

  always_comb begin
    busy        = 1'b0;
    init_hash   = 1'b0;
    load_vars   = 1'b0;
    msg_rd_en   = 1'b0;
    msg_addr    = '0;
    round_en    = 1'b0;
    round_idx   = '0;
    w_sel       = 1'b0;
    update_hash = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: ;
      INIT: begin
        busy      = 1'b1;
        init_hash = 1'b1;
      end
      FETCH: begin
        busy      = 1'b1;
        load_vars = 1'b1;
        msg_rd_en = 1'b1;
        msg_addr  = ADDR_W'({block_cnt, 4'd0});
      end
      ROUND: begin
        busy      = 1'b1;
        round_en  = 1'b1;
        round_idx = round_cnt;
        w_sel     = (round_cnt <= LAST_FETCH);
        if (round_cnt < LAST_FETCH) begin
          msg_rd_en = 1'b1;
          msg_addr  = ADDR_W'({block_cnt, word_idx});
        end
      end
      ADD: begin
        busy        = 1'b1;
        update_hash = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Self-checking bench for sha256_block_ctrl: cycle-by-cycle comparison against
// a timeline model derived from acceptance time and block count.
module tb_sha256_block_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_blocks = '0;
  logic        busy, init_hash, load_vars, msg_rd_en, round_en, w_sel, update_hash, done;
  logic [11:0] msg_addr;
  logic [5:0]  round_idx;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  typedef struct packed {
    logic        busy;
    logic        init_hash;
    logic        load_vars;
    logic        msg_rd_en;
    logic [11:0] msg_addr;
    logic        round_en;
    logic [5:0]  round_idx;
    logic        w_sel;
    logic        update_hash;
    logic        done;
  } outs_t;

  sha256_block_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_blocks  (num_blocks),
    .busy        (busy),
    .init_hash   (init_hash),
    .load_vars   (load_vars),
    .msg_rd_en   (msg_rd_en),
    .msg_addr    (msg_addr),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .w_sel       (w_sel),
    .update_hash (update_hash),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: mt = cycles since acceptance (1 = first cycle after the accepting edge), -1 idle.
  int mt = -1;
  int mn = 0;

  function automatic int last_cycle(input int n);
    return (n == 0) ? 1 : 2 + 66 * n;
  endfunction

  function automatic outs_t exp_out(input int t, input int n);
    outs_t o;
    int b, off, r;
    o = '0;
    if (t < 0) return o;
    o.busy = 1'b1;
    if (t == last_cycle(n)) begin
      o.done = 1'b1;
    end else if (t == 1) begin
      o.init_hash = 1'b1;
    end else begin
      b   = (t - 2) / 66;
      off = (t - 2) % 66;
      if (off == 0) begin
        o.load_vars = 1'b1;
        o.msg_rd_en = 1'b1;
        o.msg_addr  = 12'(b * 16);
      end else if (off <= 64) begin
        r           = off - 1;
        o.round_en  = 1'b1;
        o.round_idx = 6'(r);
        o.w_sel     = (r < 16);
        if (r <= 14) begin
          o.msg_rd_en = 1'b1;
          o.msg_addr  = 12'(b * 16 + r + 1);
        end
      end else begin
        o.update_hash = 1'b1;
      end
    end
    return o;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mt <= -1;
    end else if (mt < 0) begin
      if (start) begin
        mt <= 1;
        mn <= int'(num_blocks);
      end
    end else if (mt == last_cycle(mn)) begin
      mt <= -1;
    end else begin
      mt <= mt + 1;
    end
  end

  always @(negedge clock) begin
    outs_t e;
    if (chk_on) begin
      e = exp_out(mt, mn);
      chk("busy", 32'(busy), 32'(e.busy));
      chk("init_hash", 32'(init_hash), 32'(e.init_hash));
      chk("load_vars", 32'(load_vars), 32'(e.load_vars));
      chk("msg_rd_en", 32'(msg_rd_en), 32'(e.msg_rd_en));
      chk("round_en", 32'(round_en), 32'(e.round_en));
      chk("update_hash", 32'(update_hash), 32'(e.update_hash));
      chk("done", 32'(done), 32'(e.done));
      if (e.msg_rd_en) chk("msg_addr", 32'(msg_addr), 32'(e.msg_addr));
      if (e.round_en) begin
        chk("round_idx", 32'(round_idx), 32'(e.round_idx));
        chk("w_sel", 32'(w_sel), 32'(e.w_sel));
      end
    end
  end

  task automatic pulse_start(input int n);
    @(negedge clock);
    start      = 1'b1;
    num_blocks = 8'(n);
    @(negedge clock);
    start      = 1'b0;
    num_blocks = 8'($urandom_range(0, 255));
  endtask

  task automatic run_blocks(input int n, input int lat_exp, input bit repulse);
    int cyc, got, dones, inits, rounds, maxaddr;
    pulse_start(n);
    cyc = 1; got = -1; dones = 0; inits = 0; rounds = 0; maxaddr = 0;
    while (cyc <= lat_exp + 3 && cyc < 20000) begin
      if (msg_rd_en && int'(msg_addr) > maxaddr) maxaddr = int'(msg_addr);
      if (init_hash) inits++;
      if (round_en) rounds++;
      if (done) begin
        dones++;
        if (got < 0) got = cyc;
      end
      if (repulse) begin
        if (cyc == 30 || done) begin
          start = 1'b1;
          num_blocks = 8'd5;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("latency_n%0d", n), got, lat_exp);
    chk($sformatf("done_cnt_n%0d", n), dones, 1);
    chk($sformatf("init_cnt_n%0d", n), inits, (n > 0) ? 1 : 0);
    chk($sformatf("round_cnt_n%0d", n), rounds, 64 * n);
    if (n > 0) chk($sformatf("max_addr_n%0d", n), maxaddr, (n - 1) * 16 + 15);
    $display("txn blocks=%0d repulse=%0d latency=%0d dones=%0d max_addr=0x%0h", n, repulse, got, dones, maxaddr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rd_en"}, 32'(msg_rd_en), 0);
    chk({tag, "_addr"}, 32'(msg_addr), 0);
    chk({tag, "_round_en"}, 32'(round_en), 0);
    chk({tag, "_round_idx"}, 32'(round_idx), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clock);
    $display("txn reset_release checks=%0d", n_chk);

    run_blocks(1, 68, 1'b0);
    run_blocks(2, 134, 1'b0);
    run_blocks(0, 1, 1'b0);
    run_blocks(1, 68, 1'b1);

    // Asynchronous reset in the middle of the round loop.
    pulse_start(1);
    repeat (39) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    $display("txn mid_round_reset busy=%0d round_en=%0d", busy, round_en);
    @(negedge clock);
    reset = 1'b1;
    run_blocks(1, 68, 1'b0);

    // Random start traffic; num_blocks is also scrambled while busy.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      start = ($urandom_range(0, 15) == 0);
      num_blocks = start ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
    end
    start = 1'b0;
    waited = 0;
    while (busy && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    chk("random_drain", 32'(busy), 0);
    $display("txn random_phase checks=%0d failures=%0d", n_chk, n_fail);

    run_blocks(255, 16832, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
- Top-level sequencer for the SHA-256 compression datapath; replaces the sticky start/enable latch as the source of datapath control.
- Accepts a start request with a block count, then walks the datapath through hash init, per-block variable load, 64 rounds and hash update.
- Issues message-memory reads so words 0..15 arrive aligned with their rounds, and signals completion with a one-cycle done pulse.

Parameters:
- BLK_W, 8, width of num_blocks; maximum message length is 2^BLK_W-1 blocks.
- ADDR_W, BLK_W+4, width of msg_addr (block index concatenated with word index 0..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to hash; sampled only in IDLE.
- num_blocks  input  BLK_W  number of 512-bit blocks; latched when start is accepted.
- busy  output  1  high in every state except IDLE.
- init_hash  output  1  pulse: datapath loads H0..H7 constants into the hash registers.
- load_vars  output  1  pulse: datapath copies the hash registers into a..h.
- msg_rd_en  output  1  message memory read strobe; read data is valid the following cycle.
- msg_addr  output  ADDR_W  {block_idx, word_idx}.
- round_en  output  1  datapath performs one round this cycle.
- round_idx  output  6  current round, 0..63; selects K constant.
- w_sel  output  1  1 = use message word from memory (rounds 0..15); 0 = use scheduled W.
- update_hash  output  1  pulse: H += a..h.
- done  output  1  one-cycle pulse; digest is valid in the hash registers.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0, including round_idx and msg_addr; block_cnt = 0.
- All outputs are registered or decoded from state and counters only; no combinational path from start to any output.
- IDLE:
  - start=1 and num_blocks!=0: latch num_blocks, block_cnt=0, go to INIT.
  - start=1 and num_blocks==0: go to DONE (no init_hash, no reads).
  - start=0: stay in IDLE.
- INIT (1 cycle): init_hash=1; go to FETCH.
- FETCH (1 cycle):
  - load_vars=1, msg_rd_en=1, msg_addr={block_cnt,4'd0}.
  - Set round counter to 0; go to ROUND.
- ROUND (64 cycles):
  - round_en=1, round_idx=r, w_sel=(r<16).
  - For r<=14: msg_rd_en=1, msg_addr={block_cnt, r+1}; otherwise msg_rd_en=0.
  - At r==63: go to ADD. The round counter never wraps inside ROUND.
- ADD (1 cycle): update_hash=1.
  - If block_cnt==latched_num-1: go to DONE.
  - Otherwise: block_cnt+1, go to FETCH (no init_hash).
- DONE (1 cycle): done=1, busy=1; go to IDLE.
- start is ignored in every state except IDLE, including DONE. The earliest restart is start sampled in the IDLE cycle after done.
- Latency: start accepted at edge 0; done is high in cycle 2+66*N for N blocks. Examples: N=1 gives 68, N=2 gives 134, N=0 gives 1.
- Changes to num_blocks after acceptance have no effect.
- Reset asserted mid-operation: immediate return to IDLE, no done pulse; the datapath's partial state is don't-care.
- block_cnt is BLK_W bits; it cannot overflow because it stops at latched_num-1.

Decomposition:
- Package sha256_ctrl_pkg:
  - state enum {IDLE, INIT, FETCH, ROUND, ADD, DONE}, 3-bit encoding.
  - Constants ROUNDS=64, MSG_WORDS=16, and the round_idx width 6.
- One sub-module, sha256_round_cnt: 6-bit counter with clear, enable and a last (==63) flag.
- The FSM, block counter and address generation stay in sha256_block_ctrl.

Test Plan:
- num_blocks=1, start pulse at cycle 0:
  - init_hash at cycle 1; load_vars at cycle 2.
  - round_en cycles 3..66, with w_sel=1 for 3..18.
  - msg_addr 0..15 on cycles 2..17; update_hash at cycle 67; done at cycle 68; busy low at cycle 69.
- num_blocks=2:
  - second load_vars at cycle 68 with msg_addr=16 (0x010).
  - Single init_hash only; done at cycle 134; msg_addr covers 16..31 on cycles 68..83.
- num_blocks=0: done at cycle 1; no init_hash, msg_rd_en or round_en at any time.
- start re-pulsed during ROUND and in the DONE cycle, with num_blocks changed to 5: ignored; done count and timing identical to the N=1 case.
- reset driven low at cycle 40 (mid-ROUND):
  - Outputs 0 asynchronously, before the next edge.
  - After release, a new start with N=1 produces done exactly 68 cycles later.
- num_blocks=255: msg_addr reaches 0xFEF; done at cycle 2+66*255=16832; block_cnt does not wrap.
